// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared types and constants for the two-board guessing game.
//            - state_t : phase codes driven on state_bin (decoded by the
//                        game logic, VGA overlay and mouse UI)
//            - RES_*   : encodings of the game-logic result bus
//            - DEF_*   : default timing / width parameters
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  // GUESS and CHECK codes are decoded directly by downstream logic; keep fixed.
  typedef enum logic [5:0] {
    IDLE      = 6'd0,
    SELECT    = 6'd1,
    GUESS     = 6'd2,
    WAIT_PEER = 6'd3,
    CHECK     = 6'd4,
    WIN       = 6'd8,
    LOSE      = 6'd16
  } state_t;

  localparam logic [1:0] RES_WIN  = 2'b10;
  localparam logic [1:0] RES_LOSE = 2'b01;
  localparam logic [1:0] RES_PEND = 2'b00;
  localparam logic [1:0] RES_INV  = 2'b11;

  localparam int DEF_DEBOUNCE_CYC      = 1000;
  localparam int DEF_CHECK_TIMEOUT_CYC = 65_000_000;  // 1 s at 65 MHz
  localparam int DEF_ROUND_W           = 4;

endpackage : game_pkg
`default_nettype wire

// File: rtl/link_sync.sv
`default_nettype none
// ============================================================================
// Module   : link_sync
// Purpose  : Brings an asynchronous Pmod line into the clk domain and
//            debounces it. The output only changes after DEBOUNCE_CYC
//            consecutive synchronized samples disagree with it; a single
//            agreeing sample restarts the count.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset
//            clr  - synchronous clear (game restart)
//            din  - raw asynchronous line
//            dout - synchronized, debounced level
// Revision : 1.0 - initial release
// ============================================================================
module link_sync
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else if (clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // cnt counts consecutive samples that differ from the accepted level.
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : link_sync
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Purpose  : Turn controller for the two-board guessing game. Generates the
//            state_bin phase code, runs the ready handshake with the peer
//            board and supervises result arrival with a timeout.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            rst_sys        - synchronous game restart
//            start_btn      - rising edge starts / restarts a round
//            mouse_left     - rising edge confirms own person
//            mouse_right    - rising edge commits the guess
//            person_valid   - a nonzero own person is selected
//            peer_rdy_in    - raw ready line from peer (asynchronous)
//            resoult        - result from game logic
//            peer_rdy_out   - ready line to peer
//            state_bin      - phase code
//            timeout        - sticky, CHECK timed out
//            link_err       - sticky, peer dropped mid-round
//            round_cnt      - completed rounds (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module game_sequencer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
  parameter int CHECK_TIMEOUT_CYC = DEF_CHECK_TIMEOUT_CYC,
  parameter int ROUND_W           = DEF_ROUND_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_sys,
  input  logic               start_btn,
  input  logic               mouse_left,
  input  logic               mouse_right,
  input  logic               person_valid,
  input  logic               peer_rdy_in,
  input  logic [1:0]         resoult,
  output logic               peer_rdy_out,
  output logic [5:0]         state_bin,
  output logic               timeout,
  output logic               link_err,
  output logic [ROUND_W-1:0] round_cnt
);

  localparam int TMR_W = (CHECK_TIMEOUT_CYC > 1) ? $clog2(CHECK_TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHECK_TIMEOUT_CYC - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             peer_ok;
  logic             start_q;
  logic             left_q;
  logic             right_q;
  logic             start_edge;
  logic             left_edge;
  logic             right_edge;

  link_sync #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_peer_sync (
    .clk  (clk),
    .rst  (rst),
    .clr  (rst_sys),
    .din  (peer_rdy_in),
    .dout (peer_ok)
  );

  // Previous-sample registers keep tracking during rst_sys so a button held
  // across a restart does not produce a spurious edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      start_q <= start_btn;
      left_q  <= mouse_left;
      right_q <= mouse_right;
    end
  end

  // Edge uses the live input against last cycle's sample, so the state moves
  // on the first clock after the rise.
  assign start_edge = start_btn   & ~start_q;
  assign left_edge  = mouse_left  & ~left_q;
  assign right_edge = mouse_right & ~right_q;

  assign state_bin = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      peer_rdy_out <= 1'b0;
      timeout      <= 1'b0;
      link_err     <= 1'b0;
      round_cnt    <= '0;
      timer        <= '0;
    end else if (rst_sys) begin
      state        <= IDLE;
      peer_rdy_out <= 1'b0;
      timeout      <= 1'b0;
      link_err     <= 1'b0;
      round_cnt    <= '0;
      timer        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= SELECT;
            timeout  <= 1'b0;
            link_err <= 1'b0;
          end
        end

        SELECT: begin
          if (left_edge && person_valid) begin
            state        <= WAIT_PEER;
            peer_rdy_out <= 1'b1;
          end
        end

        WAIT_PEER: begin
          if (peer_ok) begin
            state <= GUESS;
          end else if (start_edge) begin
            state        <= SELECT;
            peer_rdy_out <= 1'b0;
          end
        end

        GUESS: begin
          if (!peer_ok) begin
            state        <= IDLE;
            link_err     <= 1'b1;
            peer_rdy_out <= 1'b0;
          end else if (right_edge) begin
            state <= CHECK;
            timer <= '0;
          end
        end

        CHECK: begin
          // Peer loss beats a result; a result beats the timeout.
          if (!peer_ok) begin
            state        <= IDLE;
            link_err     <= 1'b1;
            peer_rdy_out <= 1'b0;
          end else if (resoult == RES_WIN) begin
            state        <= WIN;
            round_cnt    <= round_cnt + ROUND_W'(1);
            peer_rdy_out <= 1'b0;
          end else if (resoult != RES_PEND) begin
            state        <= LOSE;
            round_cnt    <= round_cnt + ROUND_W'(1);
            peer_rdy_out <= 1'b0;
          end else if (timer == TMR_LAST) begin
            state        <= LOSE;
            timeout      <= 1'b1;
            round_cnt    <= round_cnt + ROUND_W'(1);
            peer_rdy_out <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        WIN, LOSE: begin
          if (start_edge) begin
            state <= SELECT;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Purpose  : Directed self-checking bench for game_sequencer with
//            DEBOUNCE_CYC = 4 and CHECK_TIMEOUT_CYC = 20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  localparam int ROUND_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               rst_sys;
  logic               start_btn;
  logic               mouse_left;
  logic               mouse_right;
  logic               person_valid;
  logic               peer_rdy_in;
  logic [1:0]         resoult;
  logic               peer_rdy_out;
  logic [5:0]         state_bin;
  logic               timeout;
  logic               link_err;
  logic [ROUND_W-1:0] round_cnt;

  int total = 0;
  int bad   = 0;

  game_sequencer #(
    .DEBOUNCE_CYC      (4),
    .CHECK_TIMEOUT_CYC (20),
    .ROUND_W           (ROUND_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_sys      (rst_sys),
    .start_btn    (start_btn),
    .mouse_left   (mouse_left),
    .mouse_right  (mouse_right),
    .person_valid (person_valid),
    .peer_rdy_in  (peer_rdy_in),
    .resoult      (resoult),
    .peer_rdy_out (peer_rdy_out),
    .state_bin    (state_bin),
    .timeout      (timeout),
    .link_err     (link_err),
    .round_cnt    (round_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1; tick(1); start_btn = 1'b0;
  endtask

  task automatic press_left();
    mouse_left = 1'b1; tick(1); mouse_left = 1'b0;
  endtask

  task automatic press_right();
    mouse_right = 1'b1; tick(1); mouse_right = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_sys = 1'b0; start_btn = 1'b0; mouse_left = 1'b0;
    mouse_right = 1'b0; person_valid = 1'b0; peer_rdy_in = 1'b0; resoult = 2'b00;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk("rst_state", 32'(state_bin), 32'd0);
    chk("rst_rdy", 32'(peer_rdy_out), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_linkerr", 32'(link_err), 32'd0);
    chk("rst_round", 32'(round_cnt), 32'd0);

    // Happy path with guards in SELECT
    press_start();
    chk("idle_to_select", 32'(state_bin), 32'd1);
    press_left();
    chk("guard_left_invalid", 32'(state_bin), 32'd1);
    press_right();
    chk("guard_right_select", 32'(state_bin), 32'd1);
    person_valid = 1'b1;
    press_left();
    chk("select_to_wait", 32'(state_bin), 32'd3);
    chk("wait_rdy_out", 32'(peer_rdy_out), 32'd1);

    // 2-cycle glitch must not pass the debouncer
    peer_rdy_in = 1'b1; tick(2); peer_rdy_in = 1'b0;
    tick(8);
    chk("glitch_ignored", 32'(state_bin), 32'd3);

    // Sustained ready: 2 sync + 4 debounce edges, then one FSM edge
    peer_rdy_in = 1'b1;
    tick(6);
    chk("wait_before_ok", 32'(state_bin), 32'd3);
    tick(1);
    chk("wait_to_guess", 32'(state_bin), 32'd2);
    chk("guess_rdy_out", 32'(peer_rdy_out), 32'd1);
    press_right();
    chk("guess_to_check", 32'(state_bin), 32'd4);
    chk("check_rdy_out", 32'(peer_rdy_out), 32'd1);
    resoult = 2'b10; tick(1); resoult = 2'b00;
    chk("check_to_win", 32'(state_bin), 32'd8);
    chk("win_round", 32'(round_cnt), 32'd1);
    chk("win_rdy_out", 32'(peer_rdy_out), 32'd0);

    // Lose path, peer_ok already high
    press_start();
    chk("win_to_select", 32'(state_bin), 32'd1);
    press_left();
    chk("lose_wait", 32'(state_bin), 32'd3);
    tick(1);
    chk("lose_guess", 32'(state_bin), 32'd2);
    press_right();
    chk("lose_check", 32'(state_bin), 32'd4);
    resoult = 2'b01; tick(1); resoult = 2'b00;
    chk("check_to_lose", 32'(state_bin), 32'd16);
    chk("lose_round", 32'(round_cnt), 32'd2);
    press_start();
    chk("lose_to_select", 32'(state_bin), 32'd1);

    // Timeout: LOSE exactly 20 cycles after CHECK entry
    press_left(); tick(1);
    press_right();
    chk("to_check", 32'(state_bin), 32'd4);
    tick(19);
    chk("to_still_check", 32'(state_bin), 32'd4);
    chk("to_not_yet", 32'(timeout), 32'd0);
    tick(1);
    chk("to_lose", 32'(state_bin), 32'd16);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_round", 32'(round_cnt), 32'd3);
    press_start();
    chk("to_sticky", 32'(timeout), 32'd1);

    // Peer drop in GUESS
    press_left(); tick(1);
    chk("drop_guess", 32'(state_bin), 32'd2);
    peer_rdy_in = 1'b0;
    tick(6);
    chk("drop_not_yet", 32'(state_bin), 32'd2);
    tick(1);
    chk("drop_idle", 32'(state_bin), 32'd0);
    chk("drop_linkerr", 32'(link_err), 32'd1);
    chk("drop_rdy_out", 32'(peer_rdy_out), 32'd0);
    press_start();
    chk("restart_select", 32'(state_bin), 32'd1);
    chk("restart_linkerr", 32'(link_err), 32'd0);
    chk("restart_timeout", 32'(timeout), 32'd0);

    // Result on the timeout cycle: result wins
    press_left();
    peer_rdy_in = 1'b1;
    tick(7);
    chk("sim_guess", 32'(state_bin), 32'd2);
    press_right();
    tick(19);
    resoult = 2'b10; tick(1); resoult = 2'b00;
    chk("sim_win", 32'(state_bin), 32'd8);
    chk("sim_no_timeout", 32'(timeout), 32'd0);
    chk("sim_round", 32'(round_cnt), 32'd4);

    // rst_sys in WIN takes effect on the clock
    peer_rdy_in = 1'b0;
    rst_sys = 1'b1; tick(1); rst_sys = 1'b0;
    chk("rstsys_state", 32'(state_bin), 32'd0);
    chk("rstsys_round", 32'(round_cnt), 32'd0);
    chk("rstsys_rdy", 32'(peer_rdy_out), 32'd0);

    // Asynchronous rst in CHECK
    press_start();
    press_left();
    peer_rdy_in = 1'b1;
    tick(7);
    press_right();
    tick(3);
    chk("pre_rst_check", 32'(state_bin), 32'd4);
    chk("pre_rst_rdy", 32'(peer_rdy_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state_bin), 32'd0);
    chk("arst_rdy", 32'(peer_rdy_out), 32'd0);
    chk("arst_linkerr", 32'(link_err), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("arst_hold", 32'(state_bin), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_game_sequencer
`default_nettype wire
